mix_sched: RTL and testbench

Round-robin scheduler that shares one serial mixing engine (the 32-bit bit-serial X/R mixer with `clk`, a synchronous active-high start/reset input and a `dirty` busy flag) between `NREQ` requesters. It latches the winning requester's operands, pulses the engine's start/reset, tracks `dirty` until the engine finishes, then returns the engine's `Y` word to that requester with a one-cycle done strobe. A watchdog aborts runs whose `dirty` never falls. It sits between the requesting key/MAC datapath clients and the single mixer instance.

---
 rtl/mix_sched.sv | 131 +++++++++++++
 tb/tb_mix_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mix_sched.sv
// mix_sched: round-robin arbiter sharing one bit-serial X/R mixing engine between NREQ requesters
module mix_sched #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int TMO  = 1023
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_r,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [W-1:0]      result,
  output logic              busy,
  output logic [W-1:0]      eng_x,
  output logic [W-1:0]      eng_r,
  output logic              eng_start,
  input  logic [W-1:0]      eng_y,
  input  logic              eng_dirty
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, CAPTURE} state_t;
  state_t          r_state, w_nxt;
  logic [PW-1:0]   r_ptr, r_owner, w_pick, w_idx;
  logic [PW:0]     w_sum;
  logic            w_found, w_tmo, w_grant, w_finish, w_abort;
  logic [15:0]     r_wdog;
  logic [NREQ-1:0] r_gnt, r_done;
  logic            r_err, r_busy, r_eng_start;
  logic [W-1:0]    r_result, r_eng_x, r_eng_r;
  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign result    = r_result;
  assign busy      = r_busy;
  assign eng_x     = r_eng_x;
  assign eng_r     = r_eng_r;
  assign eng_start = r_eng_start;
  assign w_tmo     = (r_wdog == 16'(TMO - 1));
  // first requesting index at or after the round-robin pointer, wrapping at NREQ
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      w_idx = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end
  // next state; a dirty seen while start is still asserted is stale and ignored
  always_comb begin
    w_nxt    = r_state;
    w_grant  = 1'b0;
    w_finish = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      IDLE: if (w_found) begin
        w_grant = 1'b1;
        w_nxt   = START;
      end
      START: w_nxt = WAIT_HI;
      WAIT_HI: if (w_tmo) begin
        w_abort = 1'b1;
        w_nxt   = CAPTURE;
      end else if (eng_dirty && !r_eng_start) begin
        w_nxt = WAIT_LO;
      end
      WAIT_LO: if (w_tmo) begin
        w_abort = 1'b1;
        w_nxt   = CAPTURE;
      end else if (!eng_dirty) begin
        w_finish = 1'b1;
        w_nxt    = CAPTURE;
      end
      CAPTURE: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end
  // watchdog counts engine-run cycles, cleared on every start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    r_wdog <= '0;
    else if (r_state == START)                       r_wdog <= '0;
    else if (r_state == WAIT_HI || r_state == WAIT_LO) r_wdog <= r_wdog + 16'd1;
  end
  // grant capture, engine drive and completion outputs, all registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_eng_x     <= '0;
      r_eng_r     <= '0;
      r_eng_start <= 1'b0;
      r_ptr       <= '0;
      r_owner     <= '0;
    end else begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_eng_start <= (r_state == START);
      if (w_grant) begin
        r_gnt[w_pick] <= 1'b1;
        r_eng_x       <= req_x[w_pick*W +: W];
        r_eng_r       <= req_r[w_pick*W +: W];
        r_owner       <= w_pick;
        r_ptr         <= (w_pick == PW'(NREQ - 1)) ? '0 : w_pick + 1'b1;
        r_busy        <= 1'b1;
      end
      if (w_finish || w_abort) begin
        r_done[r_owner] <= 1'b1;
        r_err           <= w_abort;
        r_result        <= w_abort ? '0 : eng_y;
      end
      if (r_state == CAPTURE) r_busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mix_sched.sv
// tb_mix_sched: directed scoreboard bench for mix_sched with a behavioural mixing-engine stub
module tb_mix_sched;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TMO  = 20;
  localparam int RUN  = 8;
  typedef struct packed {logic [3:0] d; logic [31:0] y; logic e;} exp_t;
  logic            clk = 1'b0;
  logic            reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_x, req_r;
  logic [NREQ-1:0]   gnt, done;
  logic              err, busy, eng_start;
  logic [W-1:0]      result, eng_x, eng_r;
  logic [W-1:0]      eng_y;
  logic              eng_dirty;
  logic              hang = 1'b0;
  logic              e_run = 1'b0;
  int                e_cnt = 0;
  int                n_cmp = 0;
  int                n_fail = 0;
  int                lat, c;
  exp_t              q[$];
  exp_t              m_e;
  always #5 clk = ~clk;
  mix_sched #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_x(req_x), .req_r(req_r),
    .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
    .eng_x(eng_x), .eng_r(eng_r), .eng_start(eng_start),
    .eng_y(eng_y), .eng_dirty(eng_dirty)
  );
  function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] r);
    return {x[12:0], x[31:13]} ^ (r * 32'h9E3779B1) ^ 32'h5A17C3E1;
  endfunction
  // engine stub: restart on start, dirty one cycle later, result after RUN cycles unless hung
  always @(posedge clk) begin
    if (eng_start) begin
      e_run     <= 1'b1;
      e_cnt     <= 0;
      eng_dirty <= 1'b0;
      eng_y     <= 32'hBAD0BAD0;
    end else if (e_run) begin
      e_cnt <= e_cnt + 1;
      if (e_cnt == 0) eng_dirty <= 1'b1;
      if (!hang && e_cnt == RUN) begin
        eng_dirty <= 1'b0;
        eng_y     <= mix(eng_x, eng_r);
        e_run     <= 1'b0;
      end
    end
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_ops(input int k, input logic [31:0] x, input logic [31:0] r);
    req_x[k*W +: W] = x;
    req_r[k*W +: W] = r;
  endtask
  task automatic push(input int k, input logic e);
    exp_t t;
    t.d = 4'(1 << k);
    t.y = e ? 32'h0 : mix(req_x[k*W +: W], req_r[k*W +: W]);
    t.e = e;
    q.push_back(t);
  endtask
  task automatic wait_gnt(input string tag, input logic [3:0] exp, input logic [3:0] drop, output int l);
    l = 0;
    @(negedge clk);
    while (gnt == 0 && l < 60) begin
      @(negedge clk);
      l++;
    end
    check({tag, "_gnt"}, gnt, exp);
    req = req & ~drop;
    @(negedge clk);
    check({tag, "_start"}, {gnt, eng_start, busy}, {4'b0, 1'b1, 1'b1});
    @(negedge clk);
    check({tag, "_start_end"}, eng_start, 0);
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (done == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, n < 60, 1);
    @(negedge clk);
  endtask
  // scoreboard: every done pulse must match the oldest pushed expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done !== '0) begin
      if (q.size() == 0) check("unexpected_done", done, 0);
      else begin
        m_e = q.pop_front();
        check("done_vec", done, m_e.d);
        check("result", result, m_e.y);
        check("err", err, m_e.e);
        check("busy_at_done", busy, 1);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end
  initial begin
    reset_n = 1'b0;
    req     = '0;
    req_x   = '0;
    req_r   = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {gnt, done, err, busy, eng_start}, '0);
    check("rst_result", result, 0);
    check("rst_eng_ops", {eng_x, eng_r}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) set_ops(k, 32'h10000001 * (k + 3), 32'hC0DE0000 | k);
    for (int i = 0; i < 5; i++) push(i % 4, 1'b0);
    req = 4'hF;
    for (int i = 0; i < 5; i++) wait_gnt($sformatf("cont%0d", i), 4'(1 << (i % 4)), (i == 4) ? 4'hF : 4'h0, lat);
    wait_done("cont_last");
    set_ops(0, 32'hA5A5A5A5, 32'h0F0F0F0F);
    push(0, 1'b0);
    req = 4'b0001;
    wait_gnt("single", 4'b0001, 4'b0001, lat);
    check("single_gnt_lat", lat, 0);
    c = 0;
    while (eng_dirty !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    while (eng_dirty !== 1'b0 && c < 80) begin
      @(negedge clk);
      c++;
    end
    check("single_dirty_fall", c < 80, 1);
    check("single_done_early", done, 0);
    @(negedge clk);
    check("single_done", done, 4'b0001);
    @(negedge clk);
    check("single_after", {done, busy, err}, 0);
    check("single_held", result, mix(32'hA5A5A5A5, 32'h0F0F0F0F));
    set_ops(2, 32'h13572468, 32'h8BADF00D);
    push(2, 1'b0);
    req = 4'b0100;
    wait_gnt("fair_a", 4'b0100, 4'b0100, lat);
    wait_done("fair_a");
    set_ops(0, 32'hFEEDFACE, 32'h00C0FFEE);
    push(0, 1'b0);
    push(2, 1'b0);
    req = 4'b0101;
    wait_gnt("fair_wrap", 4'b0001, 4'b0001, lat);
    wait_gnt("fair_next", 4'b0100, 4'b0100, lat);
    wait_done("fair_next");
    set_ops(1, 32'h0BADCAFE, 32'h76543210);
    push(1, 1'b0);
    req = 4'b0010;
    wait_gnt("drop", 4'b0010, 4'b0010, lat);
    wait_done("drop");
    hang = 1'b1;
    set_ops(3, 32'hDEADBEEF, 32'h12345678);
    push(3, 1'b1);
    req = 4'b1000;
    wait_gnt("wdog", 4'b1000, 4'b1000, lat);
    c = 1;
    while (done == 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("wdog_cycles", c, TMO);
    @(negedge clk);
    hang = 1'b0;
    set_ops(0, 32'h31415926, 32'h27182818);
    push(0, 1'b0);
    req = 4'b0001;
    wait_gnt("after_wdog", 4'b0001, 4'b0001, lat);
    wait_done("after_wdog");
    set_ops(1, 32'h55AA55AA, 32'hAA55AA55);
    req = 4'b0010;
    wait_gnt("arst_run", 4'b0010, 4'b0010, lat);
    c = 0;
    while (eng_dirty !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    reset_n = 1'b0;
    #1;
    check("arst_outs", {gnt, done, err, busy, eng_start}, '0);
    check("arst_result", result, 0);
    check("arst_eng_ops", {eng_x, eng_r}, 0);
    repeat (3) @(negedge clk);
    check("arst_hold", {done, busy}, 0);
    reset_n = 1'b1;
    set_ops(2, 32'h0DDBA11, 32'hCAFEBABE);
    push(2, 1'b0);
    req = 4'b0100;
    wait_gnt("post_rst", 4'b0100, 4'b0100, lat);
    check("post_rst_lat", lat, 0);
    wait_done("post_rst");
    repeat (5) @(negedge clk);
    check("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
